// File: rtl/addsub_pkg.sv
// Shared definitions for the nibble-serial add/subtract controller.
// Contents: controller state encoding, op encoding, nibble width and the
// sign-bit overflow helper used when the last nibble retires.
package addsub_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;
   localparam int   NIB_W  = 4;

   // Two's-complement overflow from sign bits only: add overflows when the
   // operand signs agree, subtract when they differ, and in both cases the
   // result sign departs from A's sign.
   function automatic logic signed_ovf(input logic op,
                                       input logic a_msb,
                                       input logic b_msb,
                                       input logic sum_msb);
      logic sign_cond;
      if (op == OP_SUB) begin
         sign_cond = (a_msb != b_msb);
      end else begin
         sign_cond = (a_msb == b_msb);
      end
      return sign_cond && (sum_msb != a_msb);
   endfunction

endpackage

// File: rtl/adder4sub.sv
// 4-bit adder/subtractor: s = a + (b xor {4{m}}) + c_in.
// Ports:
//   a, b   : 4-bit operands
//   m      : 1 inverts b (subtract when c_in is also 1)
//   c_in   : carry in
//   s      : 4-bit sum
//   c_out  : carry out of bit 3
module adder4sub
   import addsub_pkg::*;
(
   input  logic [NIB_W-1:0] a,
   input  logic [NIB_W-1:0] b,
   input  logic             m,
   input  logic             c_in,
   output logic [NIB_W-1:0] s,
   output logic             c_out
);

   logic [NIB_W:0] total_s;

   // One extra bit captures the carry out of the top sum bit.
   assign total_s = {1'b0, a} + {1'b0, b ^ {NIB_W{m}}} + {{NIB_W{1'b0}}, c_in};
   assign s       = total_s[NIB_W-1:0];
   assign c_out   = total_s[NIB_W];

endmodule

// File: rtl/addsub_seq_ctrl.sv
// Nibble-serial W-bit add/subtract controller built around one adder4sub.
// One nibble is processed per clock, LSB first, with the carry registered
// between nibbles.
// Ports:
//   clk, rst               : clock, asynchronous active-high reset
//   req_valid/req_ready    : request handshake; req_op (0 add, 1 sub),
//                            req_a, req_b sampled on the accept edge
//   rsp_valid/rsp_ready    : response handshake
//   rsp_sum, rsp_cout,     : result modulo 2^W, final carry (1 = no borrow
//   rsp_ovf                  on subtract), signed overflow
module addsub_seq_ctrl
   import addsub_pkg::*;
#(
   parameter int NIBBLES = 2,
   localparam int W      = NIB_W * NIBBLES
)(
   input  logic         clk,
   input  logic         rst,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic         req_op,
   input  logic [W-1:0] req_a,
   input  logic [W-1:0] req_b,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [W-1:0] rsp_sum,
   output logic         rsp_cout,
   output logic         rsp_ovf
);

   localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

   state_t           state_r;
   logic [W-1:0]     a_r;
   logic [W-1:0]     b_r;
   logic             op_r;
   logic [IDX_W-1:0] idx_r;
   logic             carry_r;
   logic [W-1:0]     result_r;

   logic [NIB_W-1:0] nib_a_s;
   logic [NIB_W-1:0] nib_b_s;
   logic             c_in_s;
   logic [NIB_W-1:0] nib_s_s;
   logic             c_out_s;
   logic [W-1:0]     result_next_s;

   // Select the current operand nibbles and the carry into this nibble;
   // nibble 0 takes op so subtract becomes a + ~b + 1.
   always_comb begin
      nib_a_s = a_r[idx_r*NIB_W +: NIB_W];
      nib_b_s = b_r[idx_r*NIB_W +: NIB_W];
      if (idx_r == {IDX_W{1'b0}}) begin
         c_in_s = op_r;
      end else begin
         c_in_s = carry_r;
      end
   end

   adder4sub u_adder (
      .a     (nib_a_s),
      .b     (nib_b_s),
      .m     (op_r),
      .c_in  (c_in_s),
      .s     (nib_s_s),
      .c_out (c_out_s)
   );

   // Result with the nibble being computed this cycle merged in, so the
   // DONE entry edge can publish the complete sum in one step.
   always_comb begin
      result_next_s = result_r;
      result_next_s[idx_r*NIB_W +: NIB_W] = nib_s_s;
   end

   // Controller FSM with all handshake and response outputs registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         a_r       <= {W{1'b0}};
         b_r       <= {W{1'b0}};
         op_r      <= OP_ADD;
         idx_r     <= {IDX_W{1'b0}};
         carry_r   <= 1'b0;
         result_r  <= {W{1'b0}};
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_sum   <= {W{1'b0}};
         rsp_cout  <= 1'b0;
         rsp_ovf   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (req_valid && req_ready) begin
                  a_r       <= req_a;
                  b_r       <= req_b;
                  op_r      <= req_op;
                  idx_r     <= {IDX_W{1'b0}};
                  carry_r   <= 1'b0;
                  result_r  <= {W{1'b0}};
                  req_ready <= 1'b0;
                  state_r   <= ST_RUN;
               end
            end
            ST_RUN: begin
               result_r <= result_next_s;
               carry_r  <= c_out_s;
               if (idx_r == IDX_LAST) begin
                  rsp_sum   <= result_next_s;
                  rsp_cout  <= c_out_s;
                  rsp_ovf   <= signed_ovf(op_r, a_r[W-1], b_r[W-1], result_next_s[W-1]);
                  rsp_valid <= 1'b1;
                  state_r   <= ST_DONE;
               end else begin
                  idx_r <= idx_r + IDX_W'(1);
               end
            end
            ST_DONE: begin
               // Response outputs stay untouched here; only valid drops.
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  state_r   <= ST_IDLE;
               end
            end
            default: begin
               rsp_valid <= 1'b0;
               req_ready <= 1'b1;
               state_r   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Self-checking bench for addsub_seq_ctrl (NIBBLES = 2): directed vectors,
// backpressure, back-to-back random traffic and reset during an operation.
module tb_addsub_seq_ctrl;

   localparam int NIBBLES = 2;
   localparam int W       = 4 * NIBBLES;

   logic         clk = 1'b0;
   logic         rst;
   logic         req_valid;
   logic         req_ready;
   logic         req_op;
   logic [W-1:0] req_a;
   logic [W-1:0] req_b;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [W-1:0] rsp_sum;
   logic         rsp_cout;
   logic         rsp_ovf;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   addsub_seq_ctrl #(.NIBBLES(NIBBLES)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_sum   (rsp_sum),
      .rsp_cout  (rsp_cout),
      .rsp_ovf   (rsp_ovf)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Arithmetic reference: unsigned and signed results as plain integers.
   task automatic model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] sum, output logic cout, output logic ovf);
      longint ua, ub, sa, sb, ru, rs, lim, smax, smin;
      ua   = longint'(a);
      ub   = longint'(b);
      sa   = longint'($signed(a));
      sb   = longint'($signed(b));
      lim  = longint'(1) <<< W;
      smax = (longint'(1) <<< (W - 1)) - 1;
      smin = -(longint'(1) <<< (W - 1));
      if (op) begin
         ru   = ua - ub;
         rs   = sa - sb;
         cout = (ua >= ub);
      end else begin
         ru   = ua + ub;
         rs   = sa + sb;
         cout = (ru >= lim);
      end
      sum = W'(ru);
      ovf = (rs > smax) || (rs < smin);
   endtask

   // Present a request from a negedge and return at the negedge after the accept.
   task automatic start_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                           output int acc_cyc, output logic timeout);
      int n;
      n = 0;
      req_op    = op;
      req_a     = a;
      req_b     = b;
      req_valid = 1'b1;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      timeout = !req_ready;
      acc_cyc = cyc;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   // Count clock edges after the accept edge until rsp_valid is seen.
   task automatic wait_rsp(output int lat);
      lat = 0;
      while (!rsp_valid && lat < 50) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
      req_op = 1'b0; req_a = '0; req_b = '0;
      @(negedge clk); @(negedge clk);
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
      checks++; if (rsp_sum !== '0) begin errors++; $display("FAIL reset_rsp_sum got %h want 00", rsp_sum); end
      checks++; if (rsp_cout !== 1'b0) begin errors++; $display("FAIL reset_rsp_cout got %b want 0", rsp_cout); end
      checks++; if (rsp_ovf !== 1'b0) begin errors++; $display("FAIL reset_rsp_ovf got %b want 0", rsp_ovf); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_directed();
      logic         t_op  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [W-1:0] t_a   [5] = '{8'h3C, 8'h10, 8'h00, 8'h80, 8'hFF};
      logic [W-1:0] t_b   [5] = '{8'h55, 8'h01, 8'h01, 8'h01, 8'h01};
      logic [W-1:0] t_sum [5] = '{8'h91, 8'h0F, 8'hFF, 8'h7F, 8'h00};
      logic         t_co  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      logic         t_ov  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      int acc, lat;
      logic to;
      for (int i = 0; i < 5; i++) begin
         start_op(t_op[i], t_a[i], t_b[i], acc, to);
         checks++; if (to) begin errors++; $display("FAIL dir%0d_accept req_ready timeout", i); end
         wait_rsp(lat);
         checks++; if (lat != NIBBLES) begin errors++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, NIBBLES); end
         checks++; if (rsp_sum !== t_sum[i]) begin errors++; $display("FAIL dir%0d_sum got %h want %h", i, rsp_sum, t_sum[i]); end
         checks++; if (rsp_cout !== t_co[i]) begin errors++; $display("FAIL dir%0d_cout got %b want %b", i, rsp_cout, t_co[i]); end
         checks++; if (rsp_ovf !== t_ov[i]) begin errors++; $display("FAIL dir%0d_ovf got %b want %b", i, rsp_ovf, t_ov[i]); end
         rsp_ready = 1'b1;
         @(negedge clk);
         rsp_ready = 1'b0;
         checks++;
         if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL dir%0d_handshake got valid=%b ready=%b want valid=0 ready=1", i, rsp_valid, req_ready);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] a, b, es;
      logic op, ec, eo, to, bad;
      int acc, lat;
      a = W'($urandom); b = W'($urandom); op = 1'($urandom);
      model(op, a, b, es, ec, eo);
      start_op(op, a, b, acc, to);
      wait_rsp(lat);
      checks++; if (to || lat != NIBBLES) begin errors++; $display("FAIL bp_latency got %0d want %0d", lat, NIBBLES); end
      bad = 1'b0;
      for (int i = 0; i < 5; i++) begin
         req_valid = ~req_valid;
         req_op    = 1'($urandom);
         req_a     = W'($urandom);
         req_b     = W'($urandom);
         @(negedge clk);
         if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_sum !== es ||
             rsp_cout !== ec || rsp_ovf !== eo) begin
            bad = 1'b1;
            $display("FAIL bp_hold cycle %0d got v=%b r=%b sum=%h c=%b o=%b want v=1 r=0 sum=%h c=%b o=%b",
                     i, rsp_valid, req_ready, rsp_sum, rsp_cout, rsp_ovf, es, ec, eo);
         end
      end
      checks++; if (bad) errors++;
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_release req_ready got %b want 1", req_ready); end
      checks++; if (rsp_sum !== es) begin errors++; $display("FAIL bp_sum_after got %h want %h", rsp_sum, es); end
      // Nothing offered while blocked may have been taken.
      repeat (3) @(negedge clk);
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_ghost_rsp got %b want 0", rsp_valid); end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] a, b, es;
      logic op, ec, eo, to;
      int acc, prev_acc, lat;
      int bad_val, bad_gap;
      bad_val = 0; bad_gap = 0; prev_acc = -1;
      rsp_ready = 1'b1;
      for (int i = 0; i < 200; i++) begin
         a = W'($urandom); b = W'($urandom); op = 1'($urandom);
         model(op, a, b, es, ec, eo);
         start_op(op, a, b, acc, to);
         if (to) bad_gap++;
         if (prev_acc >= 0 && acc - prev_acc != NIBBLES + 2) begin
            bad_gap++;
            $display("FAIL b2b_gap op %0d got %0d want %0d", i, acc - prev_acc, NIBBLES + 2);
         end
         prev_acc = acc;
         wait_rsp(lat);
         if (lat != NIBBLES || rsp_sum !== es || rsp_cout !== ec || rsp_ovf !== eo) begin
            bad_val++;
            $display("FAIL b2b_result op %0d %s %h %h got sum=%h c=%b o=%b lat=%0d want sum=%h c=%b o=%b lat=%0d",
                     i, op ? "sub" : "add", a, b, rsp_sum, rsp_cout, rsp_ovf, lat, es, ec, eo, NIBBLES);
         end
      end
      @(negedge clk);
      rsp_ready = 1'b0;
      checks++; if (bad_val != 0) errors++;
      checks++; if (bad_gap != 0) errors++;
   endtask

   task automatic test_reset_mid_op();
      int acc, lat;
      logic to, seen;
      // Reset while RUN is in progress.
      start_op(1'b0, 8'h7F, 8'h01, acc, to);
      #1 rst = 1'b1;
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_sum !== '0 || rsp_cout !== 1'b0 || rsp_ovf !== 1'b0) begin
         errors++; $display("FAIL rst_run_outputs got v=%b r=%b sum=%h c=%b o=%b want v=0 r=1 sum=00 c=0 o=0",
                            rsp_valid, req_ready, rsp_sum, rsp_cout, rsp_ovf);
      end
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (rsp_valid) seen = 1'b1;
      end
      checks++; if (seen) begin errors++; $display("FAIL rst_run_no_rsp got valid=1 want 0"); end
      // Reset while holding a result in DONE.
      start_op(1'b1, 8'h80, 8'h01, acc, to);
      wait_rsp(lat);
      #1 rst = 1'b1;
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || rsp_sum !== '0 || rsp_cout !== 1'b0 || rsp_ovf !== 1'b0) begin
         errors++; $display("FAIL rst_done_outputs got v=%b sum=%h c=%b o=%b want v=0 sum=00 c=0 o=0",
                            rsp_valid, rsp_sum, rsp_cout, rsp_ovf);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      // Recovery: next request completes normally.
      start_op(1'b0, 8'h3C, 8'h55, acc, to);
      wait_rsp(lat);
      checks++;
      if (to || lat != NIBBLES || rsp_sum !== 8'h91 || rsp_cout !== 1'b0 || rsp_ovf !== 1'b1) begin
         errors++; $display("FAIL rst_recover got sum=%h c=%b o=%b lat=%0d want sum=91 c=0 o=1 lat=%0d",
                            rsp_sum, rsp_cout, rsp_ovf, lat, NIBBLES);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_op();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/addsub_seq_ctrl.md
# addsub_seq_ctrl

Multi-cycle controller that runs W-bit add/subtract operations through one shared 4-bit `adder4sub` instance, one nibble per clock, LSB nibble first. It accepts operations over a valid/ready request channel and returns the sum, carry-out and signed overflow over a valid/ready response channel. It sits between the lab's operand sources (switch/register front end) and the display/result logic. It lets wide arithmetic reuse the existing 4-bit adder/subtractor datapath.

## Interface
- `NIBBLES`, default 2: number of 4-bit slices, minimum 1. W = 4*NIBBLES.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept a request.
- `req_op` in 1: 0 = add (A+B), 1 = subtract (A−B).
- `req_a` in W: operand A.
- `req_b` in W: operand B.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer takes the result.
- `rsp_sum` out W: result, modulo 2^W.
- `rsp_cout` out 1: final nibble carry-out. For subtract, 1 = no borrow.
- `rsp_ovf` out 1: two's-complement signed overflow.

## Operation
- `adder4sub` contract: S = A + (B xor {4{M}}) + c_in, with c_out as the carry out of bit 3. M is driven by the latched op for every nibble.
- Carry chain:
  - Nibble 0 gets c_in = op, which gives two's-complement subtract.
  - Nibble i>0 gets c_in = the registered c_out of nibble i−1.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`&&`req_ready`: latch a, b and op, clear the nibble index and result, then go to RUN.
- RUN:
  - Each cycle, drive the adder with nibble[idx] of a and b.
  - At the clock edge, write S into result nibble[idx], register c_out, and increment idx.
  - When idx = NIBBLES−1, go to DONE instead of incrementing.
- DONE:
  - `rsp_valid`=1 and all response outputs are held stable.
  - On `rsp_ready`, go to IDLE.
- Overflow uses sign bits only:
  - add: ovf = (a[W−1]==b[W−1]) && (sum[W−1]!=a[W−1]).
  - sub: ovf = (a[W−1]!=b[W−1]) && (sum[W−1]!=a[W−1]).
- Requests are ignored while not in IDLE. `req_a`/`req_b`/`req_op` are sampled only on the accept edge.

## Timing
- Reset values (asynchronous, immediate): state=IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_sum`=0, `rsp_cout`=0, `rsp_ovf`=0. Internal idx, carry and operand registers are also 0.
- Latency: `rsp_valid` rises exactly NIBBLES cycles after the accept edge (2 cycles at the default).
- `req_ready` is low from the cycle after the accept edge until the cycle after the response handshake.
- Response handshake:
  - A response transfers on a clock edge where `rsp_valid`&&`rsp_ready`.
  - With `rsp_ready` held high, the next request is accepted one cycle after the transfer, giving a minimum period of NIBBLES+2 cycles.
  - Holding `rsp_ready` low holds DONE and the outputs indefinitely.
- Outputs are registered. `rsp_*` changes only on the DONE entry edge and on reset.
- NIBBLES=1: RUN lasts one cycle.
- Wrap-around: the sum is truncated to W bits, and the carry appears only on `rsp_cout`.
- Reset asserted mid-RUN or in DONE: the operation is abandoned with no response, and all outputs take their reset values immediately.

## Structure
- Shared package `addsub_pkg`: state enum (IDLE, RUN, DONE), op encoding constants (OP_ADD=0, OP_SUB=1), nibble width constant 4.
- One sub-module: the existing `adder4sub`, instantiated once. No other hierarchy.
- The idx counter is $clog2(NIBBLES) bits wide, minimum 1.

## Test plan
- Reset, then NIBBLES=2, add 0x3C+0x55 → after 2 cycles `rsp_sum`=0x91, cout=0, ovf=1.
- Sub 0x10−0x01 → 0x0F, cout=1, ovf=0. Sub 0x00−0x01 → 0xFF, cout=0, ovf=0. Sub 0x80−0x01 → 0x7F, cout=1, ovf=1.
- Add 0xFF+0x01 → 0x00, cout=1, ovf=0, which checks wrap-around and the carry between nibbles.
- Backpressure: hold `rsp_ready`=0 for 5 cycles. Outputs stay stable and `req_ready`=0. Toggling `req_valid` with new operands has no effect. After release, `req_ready`=1 on the next cycle.
- Back-to-back requests with `rsp_ready`=1: accept edges are spaced 4 cycles apart. Results match a reference model for 200 random ops.
- Assert `rst` during RUN: `rsp_valid` never rises for that op, outputs go to 0, and the next request completes correctly.
